imm_sequencer: RTL
==================

IMM_SEQUENCER -- requirements
Module: imm_sequencer

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255; max cycles waited per byte before abort (1..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to build one immediate; sampled only in IDLE.
REQ-005 mode  input  2  immediate format, sampled with start: 00 sign-extend 1 byte, 01 zero-extend 1 byte, 10 two bytes (high then low), 11 reserved.
REQ-006 byte_req  output  1  high while a byte is requested from the instruction stream.
REQ-007 byte_valid  input  1  byte_in is valid this cycle.
REQ-008 byte_in  input  8  instruction-stream byte.
REQ-009 busy  output  1  high in any state other than IDLE.
REQ-010 done  output  1  one-cycle pulse when imm_out is updated or an error ends a request.
REQ-011 err  output  1  one-cycle pulse, coincident with done, for reserved mode or timeout.
REQ-012 imm_out  output  16  last successfully built immediate; held between completions.

Function
REQ-013 FSM states: IDLE, FETCH1, FETCH2, DONE.
REQ-014 IDLE, start=1, mode in {00,01,10}: latch mode, go FETCH1; start=0: stay.
REQ-015 IDLE, start=1, mode=11: go DONE with err flagged, no byte request, imm_out unchanged.
REQ-016 byte_req is decoded from state: 1 exactly in FETCH1 and FETCH2.
REQ-017 A byte is accepted only on a cycle with byte_req=1 and byte_valid=1; byte_valid at other times is ignored.
REQ-018 FETCH1 accept, mode 00: imm_out <= {8{byte_in[7]}, byte_in}; go DONE.
REQ-019 FETCH1 accept, mode 01: imm_out <= {8'h00, byte_in}; go DONE.
REQ-020 FETCH1 accept, mode 10: hold byte_in in internal hi register; go FETCH2; imm_out unchanged.
REQ-021 FETCH2 accept: imm_out <= {hi, byte_in}; go DONE.
REQ-022 DONE: done=1 (and err=1 if flagged) for exactly one cycle; next state IDLE unconditionally.
REQ-023 start while busy is ignored and not queued.
REQ-024 Timeout counter, 8 bits: cleared on entry to FETCH1 and FETCH2 and on every accept; increments each FETCH cycle without accept.
REQ-025 When the counter reaches TIMEOUT_CYCLES without an accept: go DONE with err flagged; imm_out and hi unchanged.
REQ-026 An accept in the same cycle as the timeout condition is accepted; the timeout does not fire.
REQ-027 Latency: start at cycle N with byte_valid held high -> done at N+2 (1-byte modes) or N+3 (mode 10).
REQ-028 Back-to-back: start sampled again in the IDLE cycle immediately after DONE.

Reset
REQ-029 Reset forces state IDLE; imm_out=16'h0000, hi=8'h00, counter=0, latched mode=00; done, err, byte_req, busy=0.
REQ-030 Reset asserted mid-fetch aborts the request with no done pulse; after deassertion, start is honoured only from IDLE.

Structure
REQ-031 Mode codes (00/01/10/11) and state encodings are defined in the shared processor constants include and are not hard-coded in the block.
REQ-032 Mode-00 extension uses one instance of the existing sign_extend component (8 in, 16 out); zero-extension and two-byte assembly are done locally.
REQ-033 All outputs except byte_req and busy are driven from registers.

Verification
REQ-034 mode=00, byte_in=8'h9C valid at first request -> done at N+2, imm_out=16'hFF9C, err=0.
REQ-035 mode=01, byte_in=8'h9C -> imm_out=16'h009C; mode=10, bytes 8'h12 then 8'h34 -> imm_out=16'h1234 at N+3.
REQ-036 mode=11 with start -> done=1 and err=1 at N+1, byte_req never high, imm_out unchanged.
REQ-037 TIMEOUT_CYCLES=4, mode=10, first byte accepted, then byte_valid held low -> err+done after 4 FETCH2 cycles, imm_out unchanged.
REQ-038 start pulsed during FETCH1 is ignored; reset pulsed in FETCH2 -> IDLE, no done, imm_out=16'h0000.

Source files
------------

// File: rtl/imm_sequencer_pkg.sv
// Shared processor constants for the immediate sequencer: mode codes, FSM
// state encoding and small immediate-forming helpers.
package imm_sequencer_pkg;

  localparam logic [1:0] MODE_SEXT8 = 2'b00;
  localparam logic [1:0] MODE_ZEXT8 = 2'b01;
  localparam logic [1:0] MODE_TWO   = 2'b10;
  localparam logic [1:0] MODE_RSVD  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_FETCH1 = 2'b01,
    ST_FETCH2 = 2'b10,
    ST_DONE   = 2'b11
  } state_t;

  function automatic logic [15:0] zero_extend8(input logic [7:0] b);
    return {8'h00, b};
  endfunction

  function automatic logic [15:0] join_bytes(input logic [7:0] hi_b, input logic [7:0] lo_b);
    return {hi_b, lo_b};
  endfunction

endpackage

// File: rtl/imm_sequencer_sign_extend.sv
// Sign extension from IN_W to OUT_W bits; purely combinational.
module imm_sequencer_sign_extend #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16
) (
  input  logic [IN_W-1:0]  din,
  output logic [OUT_W-1:0] dout
);

  assign dout = {{(OUT_W - IN_W){din[IN_W-1]}}, din};

endmodule

// File: rtl/imm_sequencer.sv
// Builds a 16-bit immediate from one or two instruction-stream bytes, with a
// per-byte timeout; done/err/imm_out are registered, byte_req/busy decode state.
module imm_sequencer
  import imm_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  mode,
  output logic        byte_req,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] imm_out
);

  // The counter value seen in the last waiting cycle before the abort.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [1:0]  mode_q;
  logic [7:0]  hi;
  logic [7:0]  cnt;
  logic [15:0] sext_val;
  logic        accept;
  logic        expired;

  imm_sequencer_sign_extend #(
    .IN_W  (8),
    .OUT_W (16)
  ) u_sext (
    .din  (byte_in),
    .dout (sext_val)
  );

  assign byte_req = (state == ST_FETCH1) || (state == ST_FETCH2);
  assign busy     = (state != ST_IDLE);
  assign accept   = byte_req && byte_valid;
  assign expired  = (cnt == TIMEOUT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      mode_q  <= MODE_SEXT8;
      hi      <= 8'h00;
      cnt     <= 8'h00;
      imm_out <= 16'h0000;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (mode == MODE_RSVD) begin
              state <= ST_DONE;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              mode_q <= mode;
              cnt    <= 8'h00;
              state  <= ST_FETCH1;
            end
          end
        end

        ST_FETCH1: begin
          // An accept always wins over a coincident timeout.
          if (accept) begin
            cnt <= 8'h00;
            if (mode_q == MODE_TWO) begin
              hi    <= byte_in;
              state <= ST_FETCH2;
            end else begin
              imm_out <= (mode_q == MODE_SEXT8) ? sext_val : zero_extend8(byte_in);
              done    <= 1'b1;
              state   <= ST_DONE;
            end
          end else if (expired) begin
            cnt   <= 8'h00;
            done  <= 1'b1;
            err   <= 1'b1;
            state <= ST_DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        ST_FETCH2: begin
          if (accept) begin
            cnt     <= 8'h00;
            imm_out <= join_bytes(hi, byte_in);
            done    <= 1'b1;
            state   <= ST_DONE;
          end else if (expired) begin
            cnt   <= 8'h00;
            done  <= 1'b1;
            err   <= 1'b1;
            state <= ST_DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end

        ST_DONE: state <= ST_IDLE;

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
